alu_add_div_unit: RTL and testbench

Clocked arithmetic unit that bundles the 8-bit ripple-carry adder and 8-bit unsigned divider of the ALU into one registered block. The adder is a free-running, one-cycle pipelined path. The divider is a multi-cycle restoring divider with a start/busy/done handshake. It sits in the ALU datapath between the operand registers and the result multiplexer.

---
 rtl/alu_add_div_unit_pkg.sv | 44 ++++
 rtl/alu_add_div_unit_full_adder_cell.sv | 18 +
 rtl/alu_add_div_unit.sv | 112 +++++++++++
 tb/tb_alu_add_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_add_div_unit_pkg.sv
// Shared ALU definitions: widths, divider step count, FSM states, divider step helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_add_div_unit_pkg;

    localparam int DATA_W     = 8;
    localparam int DIV_STEPS  = 8;
    localparam int STEP_CNT_W = 3;

    // Divider control states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

    // Divider working registers. The partial remainder is kept at DATA_W bits:
    // after every step it is strictly below the divisor (or equal to the shifted
    // value when the divisor is zero, which never exceeds DATA_W bits because it
    // only ever accumulates dividend bits), so the ninth bit only exists
    // transiently inside the compare/subtract.
    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quo;
    } div_acc_t;

    // One restoring step, MSB first: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits, and record the quotient bit.
    function automatic div_acc_t div_step(input div_acc_t acc, input logic [DATA_W-1:0] divisor);
        div_acc_t        nxt;
        logic [DATA_W:0] shifted;
        logic [DATA_W:0] divisor_ext;
        shifted     = {acc.rem, acc.quo[DATA_W-1]};
        divisor_ext = {1'b0, divisor};
        nxt.quo     = {acc.quo[DATA_W-2:0], 1'b0};
        if (shifted >= divisor_ext) begin
            nxt.rem    = DATA_W'(shifted - divisor_ext);
            nxt.quo[0] = 1'b1;
        end else begin
            nxt.rem    = DATA_W'(shifted);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/alu_add_div_unit_full_adder_cell.sv
// One-bit full adder cell used to build the ripple-carry adder.
// Latency: combinational.
// Backpressure: none.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign sum     = a_xor_b ^ cin;
    assign cout    = (a & b) | (cin & a_xor_b);

endmodule

// File: rtl/alu_add_div_unit.sv
// Registered 8-bit ripple-carry adder plus 8-bit restoring unsigned divider.
// Latency: adder 1 cycle; divider 8 cycles from acceptance to div_done.
// Backpressure: div_start is ignored while div_busy=1; adder is free-running.
module alu_add_div_unit
    import alu_add_div_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   add_a,
    input  logic [DATA_W-1:0]   add_b,
    output logic [DATA_W-1:0]   add_sum,
    output logic                add_cout,
    input  logic                div_start,
    input  logic [DATA_W-1:0]   div_dividend,
    input  logic [DATA_W-1:0]   div_divisor,
    output logic                div_busy,
    output logic                div_done,
    output logic [DATA_W-1:0]   div_quotient,
    output logic [DATA_W-1:0]   div_rest
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(DIV_STEPS - 1);

    // ------------------------------------------------------------------
    // Adder: ripple chain, carry-in to bit 0 tied low
    // ------------------------------------------------------------------
    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] sum_comb;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        full_adder_cell u_fa (
            .a    (add_a[i]),
            .b    (add_b[i]),
            .cin  (carry[i]),
            .sum  (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // Capture the adder result every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_sum  <= '0;
            add_cout <= 1'b0;
        end else begin
            add_sum  <= sum_comb;
            add_cout <= carry[DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Divider: restoring, one quotient bit per cycle
    // ------------------------------------------------------------------
    div_state_e              state;
    logic [STEP_CNT_W-1:0]   step_cnt;
    div_acc_t                acc;
    logic [DATA_W-1:0]       divisor_q;
    div_acc_t                acc_nxt;

    // Next remainder/quotient pair for the current step
    always_comb begin
        acc_nxt = div_step(acc, divisor_q);
    end

    // Divider FSM: accept in IDLE, iterate in RUN, publish on the last step.
    // A zero divisor takes the same path; the algorithm naturally yields
    // quotient all-ones and remainder equal to the dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step_cnt     <= '0;
            acc          <= '0;
            divisor_q    <= '0;
            div_busy     <= 1'b0;
            div_done     <= 1'b0;
            div_quotient <= '0;
            div_rest     <= '0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        acc.rem   <= '0;
                        acc.quo   <= div_dividend;
                        divisor_q <= div_divisor;
                        step_cnt  <= '0;
                        div_busy  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc      <= acc_nxt;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        div_quotient <= acc_nxt.quo;
                        div_rest     <= acc_nxt.rem;
                        div_busy     <= 1'b0;
                        div_done     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_add_div_unit.sv
module tb_alu_add_div_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] add_a, add_b, add_sum;
    logic       add_cout;
    logic       div_start;
    logic [7:0] div_dividend, div_divisor, div_quotient, div_rest;
    logic       div_busy, div_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_add_div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .div_rest     (div_rest)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } add_vec_t;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] quo;
        logic [7:0] rem;
    } div_vec_t;

    add_vec_t av [4];
    div_vec_t dv [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edge E0: present operands with div_start for one edge
    task automatic start_div(input logic [7:0] dvd, input logic [7:0] dvs);
        div_start    = 1'b1;
        div_dividend = dvd;
        div_divisor  = dvs;
        tick();
        div_start = 1'b0;
        check("busy_after_accept", {31'd0, div_busy}, 32'd1);
    endtask

    // Run n edges; div_done must appear exactly on the last one with the expected result
    task automatic finish_div(input int n, input logic [7:0] quo, input logic [7:0] rem, input string name);
        int early = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i < n && (div_done || !div_busy)) early++;
        end
        check({name, "_early_done"}, early, 0);
        check({name, "_done"}, {31'd0, div_done}, 32'd1);
        check({name, "_busy_low"}, {31'd0, div_busy}, 32'd0);
        check({name, "_quo"}, {24'd0, div_quotient}, {24'd0, quo});
        check({name, "_rem"}, {24'd0, div_rest}, {24'd0, rem});
    endtask

    initial begin
        av[0] = '{8'd5,   8'd3,   8'd8,   1'b0};
        av[1] = '{8'd255, 8'd1,   8'd0,   1'b1};
        av[2] = '{8'd255, 8'd255, 8'd254, 1'b1};
        av[3] = '{8'd0,   8'd0,   8'd0,   1'b0};

        dv[0] = '{8'd178, 8'd5, 8'd35,  8'd3};
        dv[1] = '{8'd100, 8'd7, 8'd14,  8'd2};
        dv[2] = '{8'd15,  8'd3, 8'd5,   8'd0};
        dv[3] = '{8'd10,  8'd0, 8'd255, 8'd10};
        dv[4] = '{8'd7,   8'd9, 8'd0,   8'd7};
        dv[5] = '{8'd255, 8'd1, 8'd255, 8'd0};

        rst_n        = 1'b0;
        add_a        = 8'd17;
        add_b        = 8'd9;
        div_start    = 1'b0;
        div_dividend = 8'd0;
        div_divisor  = 8'd0;

        // Reset state
        #22;
        check("rst_sum",  {24'd0, add_sum}, 32'd0);
        check("rst_cout", {31'd0, add_cout}, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_quo",  {24'd0, div_quotient}, 32'd0);
        check("rst_rem",  {24'd0, div_rest}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Adder table: result visible one edge after operands
        for (int i = 0; i < 4; i++) begin
            add_a = av[i].a;
            add_b = av[i].b;
            tick();
            check($sformatf("add%0d_sum", i), {24'd0, add_sum}, {24'd0, av[i].sum});
            check($sformatf("add%0d_cout", i), {31'd0, add_cout}, {31'd0, av[i].cout});
        end

        // Divider table: done exactly 8 edges after acceptance, one-cycle pulse, result held
        for (int i = 0; i < 6; i++) begin
            start_div(dv[i].dvd, dv[i].dvs);
            finish_div(8, dv[i].quo, dv[i].rem, $sformatf("div%0d", i));
            tick();
            check($sformatf("div%0d_done_pulse", i), {31'd0, div_done}, 32'd0);
            check($sformatf("div%0d_quo_held", i), {24'd0, div_quotient}, {24'd0, dv[i].quo});
        end

        // div_start during busy with other operands is ignored
        start_div(8'd178, 8'd5);
        tick();
        tick();
        div_start    = 1'b1;
        div_dividend = 8'd200;
        div_divisor  = 8'd9;
        tick();
        div_start = 1'b0;
        finish_div(5, 8'd35, 8'd3, "ign");
        tick();
        check("ign_not_queued", {31'd0, div_busy}, 32'd0);

        // Back-to-back: start in the div_done cycle, second done 9 edges later
        start_div(8'd100, 8'd7);
        finish_div(8, 8'd14, 8'd2, "b2b_first");
        div_start    = 1'b1;
        div_dividend = 8'd15;
        div_divisor  = 8'd3;
        tick();
        div_start = 1'b0;
        check("b2b_accept_busy", {31'd0, div_busy}, 32'd1);
        check("b2b_accept_done_low", {31'd0, div_done}, 32'd0);
        for (int i = 1; i <= 7; i++) tick();
        check("b2b_first_quo_held", {24'd0, div_quotient}, 32'd14);
        check("b2b_first_rem_held", {24'd0, div_rest}, 32'd2);
        check("b2b_no_early_done", {31'd0, div_done}, 32'd0);
        tick();
        check("b2b_second_done", {31'd0, div_done}, 32'd1);
        check("b2b_second_quo", {24'd0, div_quotient}, 32'd5);
        check("b2b_second_rem", {24'd0, div_rest}, 32'd0);
        tick();

        // Adder traffic during a division
        start_div(8'd200, 8'd6);
        for (int i = 1; i <= 8; i++) begin
            int s;
            add_a = 8'(i * 40);
            add_b = 8'(i * 50);
            s = ((i * 40) % 256) + ((i * 50) % 256);
            tick();
            check($sformatf("mix_add%0d", i), {23'd0, add_cout, add_sum}, 32'(s));
        end
        check("mix_done", {31'd0, div_done}, 32'd1);
        check("mix_quo", {24'd0, div_quotient}, 32'd33);
        check("mix_rem", {24'd0, div_rest}, 32'd2);
        tick();

        // Reset mid-division: everything clears, no done afterwards
        start_div(8'd100, 8'd7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {31'd0, div_busy}, 32'd0);
        check("mrst_done", {31'd0, div_done}, 32'd0);
        check("mrst_quo",  {24'd0, div_quotient}, 32'd0);
        check("mrst_rem",  {24'd0, div_rest}, 32'd0);
        check("mrst_sum",  {23'd0, add_cout, add_sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (div_done || div_busy) seen++;
            end
            check("mrst_no_done_after", seen, 0);
        end
        check("mrst_quo_after", {24'd0, div_quotient}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
